// File: rtl/gp_regfile_sb_pkg.sv
// gp_regfile_sb_pkg: default IR field positions and the register-select one-hot helper
package gp_regfile_sb_pkg;
    localparam int RA_LSB_DEF  = 23;
    localparam int RB_LSB_DEF  = 19;
    localparam int RC_LSB_DEF  = 15;
    localparam int CONST_W_DEF = 19;
    localparam int MAX_IDX_W   = 8;
    localparam int MAX_REGS    = 1 << MAX_IDX_W;
    typedef logic [MAX_IDX_W-1:0] reg_idx_t;
    typedef logic [MAX_REGS-1:0]  reg_vec_t;
    function automatic reg_vec_t onehot(input reg_idx_t idx);
        return reg_vec_t'(1) << idx;
    endfunction
endpackage

// File: rtl/gp_regfile_sb_reg_field_decode.sv
// reg_field_decode: ra/rb/rc selection from IR fields and sign-extended IR constant
module reg_field_decode
    import gp_regfile_sb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int IDX_W   = $clog2(NREGS),
    parameter int RA_LSB  = RA_LSB_DEF,
    parameter int RB_LSB  = RB_LSB_DEF,
    parameter int RC_LSB  = RC_LSB_DEF,
    parameter int CONST_W = CONST_W_DEF
) (
    input  logic [WIDTH-1:0] ir,
    input  logic             gra,
    input  logic             grb,
    input  logic             grc,
    output logic [NREGS-1:0] sel,
    output logic [WIDTH-1:0] c_sign_extended
);
    logic unused_ir;
    assign unused_ir = ^ir;
    always_comb begin
        sel = (gra ? NREGS'(onehot(reg_idx_t'(ir[RA_LSB+:IDX_W]))) : '0)
            | (grb ? NREGS'(onehot(reg_idx_t'(ir[RB_LSB+:IDX_W]))) : '0)
            | (grc ? NREGS'(onehot(reg_idx_t'(ir[RC_LSB+:IDX_W]))) : '0);
        c_sign_extended = {{(WIDTH-CONST_W){ir[CONST_W-1]}}, ir[CONST_W-1:0]};
    end
endmodule

// File: rtl/gp_regfile_sb.sv
// gp_regfile_sb: Mini-SRC register file with a second write-back port and per-register busy scoreboard
module gp_regfile_sb
    import gp_regfile_sb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int IDX_W   = $clog2(NREGS),
    parameter int RA_LSB  = RA_LSB_DEF,
    parameter int RB_LSB  = RB_LSB_DEF,
    parameter int RC_LSB  = RC_LSB_DEF,
    parameter int CONST_W = CONST_W_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] ir,
    input  logic             gra,
    input  logic             grb,
    input  logic             grc,
    input  logic             rin,
    input  logic             rout,
    input  logic             baout,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] c_sign_extended,
    input  logic             reserve,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic [WIDTH-1:0] wb_data,
    output logic             busy_hit,
    output logic [NREGS-1:0] busy,
    output logic             wb_err
);
    logic [NREGS-1:0]            sel, wr_en, wb_oh, busy_q, busy_d;
    logic                        wb_err_q, wb_err_d, rd_en;
    logic [NREGS-1:0][WIDTH-1:0] rd;

    reg_field_decode #(
        .WIDTH(WIDTH), .NREGS(NREGS), .IDX_W(IDX_W), .RA_LSB(RA_LSB),
        .RB_LSB(RB_LSB), .RC_LSB(RC_LSB), .CONST_W(CONST_W)
    ) u_decode (
        .ir(ir), .gra(gra), .grb(grb), .grc(grc), .sel(sel), .c_sign_extended(c_sign_extended)
    );

    assign rd_en = rout | baout;

    // A same-cycle reservation re-arms busy even while a write-back retires it
    always_comb begin
        wr_en    = sel & {NREGS{rin}};
        wb_oh    = wb_valid ? NREGS'(onehot(reg_idx_t'(wb_idx))) : '0;
        busy_d   = (busy_q & ~wb_oh) | (reserve ? sel : '0);
        wb_err_d = wb_err_q | (wb_valid & ~busy_q[wb_idx]);
        busy_hit = |(sel & busy_q) & rd_en;
        bus_out  = '0;
        for (int k = 0; k < NREGS; k++) bus_out |= rd[k];
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        logic [WIDTH-1:0] reg_q, reg_d;
        assign reg_d = wr_en[i] ? bus_in : wb_oh[i] ? wb_data : reg_q;
        assign rd[i] = (rd_en && sel[i] && !(baout && i == 0)) ? reg_q : '0;
        always_ff @(posedge clock) reg_q <= clear ? '0 : reg_d;
    end

    always_ff @(posedge clock) begin
        busy_q   <= clear ? '0 : busy_d;
        wb_err_q <= clear ? 1'b0 : wb_err_d;
    end

    assign busy   = busy_q;
    assign wb_err = wb_err_q;
endmodule

// File: tb/tb_gp_regfile_sb.sv
// tb_gp_regfile_sb: directed stimulus against a behavioural register/scoreboard model, default and widened configs
module tb_gp_regfile_sb;
    localparam logic [3:0] RIN = 4'b1000, ROUT = 4'b0100, BAOUT = 4'b0010, RES = 4'b0001, NONE = 4'b0000;
    localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001, G0 = 3'b000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, gra, grb, grc, rin, rout, baout, reserve, wb_valid, busy_hit, wb_err;
    logic [31:0] ir, bus_in, wb_data, bus_out, cse;
    logic [3:0]  wb_idx;
    logic [15:0] busy;

    gp_regfile_sb dut (
        .clock(clk), .clear(clear), .ir(ir), .gra(gra), .grb(grb), .grc(grc),
        .rin(rin), .rout(rout), .baout(baout), .bus_in(bus_in), .bus_out(bus_out),
        .c_sign_extended(cse), .reserve(reserve), .wb_valid(wb_valid), .wb_idx(wb_idx),
        .wb_data(wb_data), .busy_hit(busy_hit), .busy(busy), .wb_err(wb_err)
    );

    logic        w_clear, w_gra, w_grb, w_grc, w_rin, w_rout, w_baout, w_reserve, w_wb_valid, w_busy_hit, w_wb_err;
    logic [63:0] w_ir, w_bus_in, w_wb_data, w_bus_out, w_cse;
    logic [4:0]  w_wb_idx;
    logic [31:0] w_busy;

    gp_regfile_sb #(
        .WIDTH(64), .NREGS(32), .IDX_W(5), .RA_LSB(22), .RB_LSB(17), .RC_LSB(12)
    ) dut64 (
        .clock(clk), .clear(w_clear), .ir(w_ir), .gra(w_gra), .grb(w_grb), .grc(w_grc),
        .rin(w_rin), .rout(w_rout), .baout(w_baout), .bus_in(w_bus_in), .bus_out(w_bus_out),
        .c_sign_extended(w_cse), .reserve(w_reserve), .wb_valid(w_wb_valid), .wb_idx(w_wb_idx),
        .wb_data(w_wb_data), .busy_hit(w_busy_hit), .busy(w_busy), .wb_err(w_wb_err)
    );

    int checks = 0, failures = 0;
    bit armed = 1'b0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    logic [31:0] m_reg [16];
    bit          m_busy [16];
    bit          m_err;

    function automatic bit picked(int k);
        return (gra && int'(ir[26:23]) == k) || (grb && int'(ir[22:19]) == k) || (grc && int'(ir[18:15]) == k);
    endfunction

    initial begin
        for (int k = 0; k < 16; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_err = 1'b0;
    end

    always @(posedge clk) begin : model
        logic [31:0] nr [16];
        bit          nb [16];
        bit          ne;
        ne = m_err;
        for (int k = 0; k < 16; k++) begin
            nr[k] = m_reg[k];
            nb[k] = m_busy[k];
            if (wb_valid && int'(wb_idx) == k) begin
                nr[k] = wb_data;
                nb[k] = 1'b0;
                if (!m_busy[k]) ne = 1'b1;
            end
            if (rin && picked(k)) nr[k] = bus_in;
            if (reserve && picked(k)) nb[k] = 1'b1;
            if (clear) begin
                nr[k] = '0;
                nb[k] = 1'b0;
            end
        end
        m_reg  = nr;
        m_busy = nb;
        m_err  = clear ? 1'b0 : ne;
    end

    always @(negedge clk) if (armed) begin : cmp
        logic [31:0] eb;
        logic [15:0] ebusy;
        logic        eh;
        eb = '0;
        eh = 1'b0;
        ebusy = '0;
        for (int k = 0; k < 16; k++) begin
            ebusy[k] = m_busy[k];
            if (picked(k) && (rout || baout)) begin
                if (!(baout && k == 0)) eb |= m_reg[k];
                if (m_busy[k]) eh = 1'b1;
            end
        end
        chk("m_bus_out", 64'(bus_out), 64'(eb));
        chk("m_busy_hit", 64'(busy_hit), 64'(eh));
        chk("m_busy", 64'(busy), 64'(ebusy));
        chk("m_wb_err", 64'(wb_err), 64'(m_err));
        chk("m_csext", 64'(cse), 64'({{13{ir[18]}}, ir[18:0]}));
    end

    function automatic logic [31:0] f(int a, int b, int c);
        return (32'(a) << 23) | (32'(b) << 19) | (32'(c) << 15);
    endfunction

    function automatic logic [63:0] f64(int a, int b, int c);
        return (64'(a) << 22) | (64'(b) << 17) | (64'(c) << 12);
    endfunction

    task automatic drive(input logic [31:0] i, input logic [2:0] g, input logic [3:0] c,
                         input logic wv, input logic [3:0] wi, input logic [31:0] wd, input logic [31:0] bi);
        @(posedge clk); #1;
        clear = 1'b0;
        ir = i;
        {gra, grb, grc} = g;
        {rin, rout, baout, reserve} = c;
        wb_valid = wv;
        wb_idx = wi;
        wb_data = wd;
        bus_in = bi;
        @(negedge clk);
    endtask

    task automatic drive64(input logic [63:0] i, input logic [2:0] g, input logic [3:0] c,
                           input logic wv, input logic [4:0] wi, input logic [63:0] wd, input logic [63:0] bi);
        @(posedge clk); #1;
        w_clear = 1'b0;
        w_ir = i;
        {w_gra, w_grb, w_grc} = g;
        {w_rin, w_rout, w_baout, w_reserve} = c;
        w_wb_valid = wv;
        w_wb_idx = wi;
        w_wb_data = wd;
        w_bus_in = bi;
        @(negedge clk);
    endtask

    initial begin
        {clear, gra, grb, grc, rin, rout, baout, reserve, wb_valid} = 9'b1_0000_0000;
        ir = '0; bus_in = '0; wb_data = '0; wb_idx = '0;
        {w_clear, w_gra, w_grb, w_grc, w_rin, w_rout, w_baout, w_reserve, w_wb_valid} = 9'b1_0000_0000;
        w_ir = '0; w_bus_in = '0; w_wb_data = '0; w_wb_idx = '0;
        @(posedge clk); #1;
        clear = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_wb_err", 64'(wb_err), 64'h0);
        chk("rst_bus_out", 64'(bus_out), 64'h0);
        chk("rst_busy_hit", 64'(busy_hit), 64'h0);

        drive(f(3, 0, 0), GA, RIN, 0, 0, 0, 32'hDEADBEEF);
        drive(f(3, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("r3_read", 64'(bus_out), 64'hDEADBEEF);
        for (int k = 0; k < 16; k++) if (k != 3) begin
            drive(f(k, 0, 0), GA, ROUT, 0, 0, 0, 0);
            chk("other_zero", 64'(bus_out), 64'h0);
        end

        drive(f(0, 0, 0), GA, RIN, 0, 0, 0, 32'h12345678);
        drive(f(0, 0, 0), GB, BAOUT, 0, 0, 0, 0);
        chk("r0_baout", 64'(bus_out), 64'h0);
        drive(f(0, 0, 0), GB, ROUT, 0, 0, 0, 0);
        chk("r0_rout", 64'(bus_out), 64'h12345678);

        drive(f(0, 0, 5), GC, RES, 0, 0, 0, 0);
        drive(f(5, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("sb_busy5", 64'(busy), 64'h0020);
        chk("sb_hit5", 64'(busy_hit), 64'h1);
        drive(f(5, 0, 0), GA, ROUT, 1, 5, 32'hA5A5A5A5, 0);
        chk("sb_hit_wb_cycle", 64'(busy_hit), 64'h1);
        drive(f(5, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("sb_r5", 64'(bus_out), 64'hA5A5A5A5);
        chk("sb_hit_clr", 64'(busy_hit), 64'h0);
        chk("sb_busy_clr", 64'(busy), 64'h0);

        drive(f(0, 0, 7), GC, RES, 0, 0, 0, 0);
        drive(f(7, 0, 0), GA, RIN, 1, 7, 32'h2, 32'h1);
        drive(f(7, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("col_rin_wb_data", 64'(bus_out), 64'h1);
        chk("col_rin_wb_busy", 64'(busy), 64'h0);
        drive(f(0, 0, 7), GC, RES, 0, 0, 0, 0);
        drive(f(0, 0, 7), GC, RES, 1, 7, 32'h3, 0);
        drive(f(7, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("col_res_wb_data", 64'(bus_out), 64'h3);
        chk("col_res_wb_busy", 64'(busy), 64'h0080);
        chk("col_res_wb_err", 64'(wb_err), 64'h0);
        drive(0, G0, NONE, 1, 7, 32'h4, 0);
        drive(f(8, 0, 0), GA, RIN | RES, 0, 0, 0, 32'h88);
        drive(f(8, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("col_rin_res_data", 64'(bus_out), 64'h88);
        chk("col_rin_res_busy", 64'(busy), 64'h0100);
        drive(0, G0, NONE, 1, 8, 32'h8, 0);

        drive(f(1, 2, 0), GA | GB, RIN, 0, 0, 0, 32'h55);
        drive(f(0, 2, 0), GB, ROUT, 0, 0, 0, 0);
        chk("union_r2", 64'(bus_out), 64'h55);

        drive(f(9, 0, 0), GA, ROUT, 1, 9, 32'h99, 0);
        chk("err_before", 64'(wb_err), 64'h0);
        drive(f(9, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("err_set", 64'(wb_err), 64'h1);
        chk("err_data", 64'(bus_out), 64'h99);
        for (int k = 0; k < 3; k++) drive(0, G0, NONE, 0, 0, 0, 0);
        chk("err_sticky", 64'(wb_err), 64'h1);

        drive(32'h0004_0000, G0, NONE, 0, 0, 0, 0);
        chk("csext_neg", 64'(cse), 64'hFFFC0000);
        drive(32'h0003_FFFF, G0, NONE, 0, 0, 0, 0);
        chk("csext_pos", 64'(cse), 64'h0003FFFF);

        @(posedge clk); #1;
        clear = 1'b1; ir = f(0, 0, 10); {gra, grb, grc} = GC; {rin, rout, baout, reserve} = RES;
        wb_valid = 1'b1; wb_idx = 4'd9; wb_data = 32'h77;
        @(negedge clk);
        drive(f(9, 0, 10), GA | GC, ROUT, 0, 0, 0, 0);
        chk("clr_r9", 64'(bus_out), 64'h0);
        chk("clr_busy", 64'(busy), 64'h0);
        chk("clr_err", 64'(wb_err), 64'h0);
        armed = 1'b0;

        drive64(0, G0, NONE, 0, 0, 0, 0);
        chk("w_rst_busy", 64'(w_busy), 64'h0);
        chk("w_rst_err", 64'(w_wb_err), 64'h0);
        chk("w_rst_bus", w_bus_out, 64'h0);
        drive64(f64(3, 0, 0), GA, RIN, 0, 0, 0, 64'hDEADBEEF_CAFEF00D);
        drive64(f64(3, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("w_r3", w_bus_out, 64'hDEADBEEF_CAFEF00D);
        drive64(f64(4, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("w_r4", w_bus_out, 64'h0);
        drive64(f64(31, 0, 0), GA, RIN, 0, 0, 0, 64'h1111_2222_3333_4444);
        drive64(f64(0, 31, 0), GB, ROUT, 0, 0, 0, 0);
        chk("w_r31", w_bus_out, 64'h1111_2222_3333_4444);
        drive64(f64(0, 0, 5), GC, RES, 0, 0, 0, 0);
        drive64(f64(5, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("w_busy5", 64'(w_busy), 64'h20);
        chk("w_hit5", 64'(w_busy_hit), 64'h1);
        drive64(f64(5, 0, 0), GA, ROUT, 1, 5, 64'hA5A5A5A5_A5A5A5A5, 0);
        drive64(f64(5, 0, 0), GA, ROUT, 0, 0, 0, 0);
        chk("w_r5", w_bus_out, 64'hA5A5A5A5_A5A5A5A5);
        chk("w_busy_clr", 64'(w_busy), 64'h0);
        chk("w_hit_clr", 64'(w_busy_hit), 64'h0);
        chk("w_err", 64'(w_wb_err), 64'h0);
        drive64(64'h4_0000, G0, NONE, 0, 0, 0, 0);
        chk("w_csext", w_cse, 64'hFFFFFFFF_FFFC0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gp_regfile_sb.md
# gp_regfile_sb

Parametrised general-purpose register file for the Mini-SRC single-bus datapath, with a write-back scoreboard for long-latency results. Register selection is decoded from the IR fields (ra/rb/rc) under Gra/Grb/Grc with Rin/Rout strobes. A second write port accepts results from multi-cycle units such as MUL/DIV. Per-register busy bits let the control unit stall reads of registers whose results are still pending.

## Interface
- WIDTH, 32: register and bus width
- NREGS, 16: number of registers, power of two, ≥2
- IDX_W, $clog2(NREGS): register index width
- RA_LSB, 23: LSB of ra field in ir
- RB_LSB, 19: LSB of rb field in ir
- RC_LSB, 15: LSB of rc field in ir
- CONST_W, 19: width of IR constant field ir[CONST_W-1:0]

Ports:
- clock  in  1  sole clock, rising edge
- clear  in  1  reset; synchronous, active-high
- ir  in  WIDTH  instruction register contents
- gra, grb, grc  in  1 each  select ra/rb/rc field
- rin  in  1  write BusMuxOut into selected register(s)
- rout  in  1  drive selected register onto bus_out
- baout  in  1  like rout, but R0 reads as 0
- bus_in  in  WIDTH  BusMuxOut
- bus_out  out  WIDTH  register read data to bus mux
- c_sign_extended  out  WIDTH  ir[CONST_W-1:0] sign-extended
- reserve  in  1  mark selected register(s) busy
- wb_valid  in  1  write-back strobe from long-latency unit
- wb_idx  in  IDX_W  write-back register index
- wb_data  in  WIDTH  write-back data
- busy_hit  out  1  a register selected for rout/baout is busy
- busy  out  NREGS  busy vector
- wb_err  out  1  sticky: write-back to a non-busy register

## Operation
- Decode: sel = OR of onehot(ir[RA_LSB+:IDX_W]) & gra, onehot(rb) & grb, onehot(rc) & grc. Multiple G signals give the union.
- Write enable: wr_en = sel & {NREGS{rin}}. Each enabled register loads bus_in.
- Read: when rout or baout is asserted, bus_out = OR over selected registers. If baout is asserted and R0 is selected, R0 contributes 0. Otherwise bus_out = 0.
- R0 is writable. It reads as zero only under baout.
- Reserve: busy |= sel when reserve is asserted.
- Write-back: when wb_valid is asserted, reg[wb_idx] ← wb_data and busy[wb_idx] ← 0. If busy[wb_idx] was 0 beforehand, wb_err ← 1 (sticky until clear), and the write still happens.
- busy_hit = |(sel & busy) & (rout | baout).
- Simultaneous events on the same register in one cycle:
  - rin and wb_valid: the bus write wins the data. Busy is still cleared.
  - reserve and wb_valid: wb_data is written, busy ends at 1 (the new reservation wins).
  - rin and reserve: data is written and busy is set.
- On clear: all registers, busy and wb_err become 0. Any in-flight write-back or reservation that cycle is discarded.

## Timing
- Reads are combinational. bus_out, busy_hit and c_sign_extended are valid in the same cycle as ir and the strobes.
- Writes, busy updates and wb_err take effect at the next rising edge. There is no write-through bypass: a register written in cycle n reads its new value from cycle n+1.
- Reset values: bus_out 0 (no rout/baout), busy 0, busy_hit 0, wb_err 0, all registers 0.
- Write-back latency to visibility is one cycle. wb_valid may be asserted every cycle.

## Structure
- Shared package holds the default field LSBs (RA_LSB/RB_LSB/RC_LSB), CONST_W, and a onehot decode function. The datapath, control unit and this block all import it.
- One sub-module: reg_field_decode. It takes ir and gra/grb/grc and produces the sel one-hot and c_sign_extended.
- Storage and the scoreboard stay in gp_regfile_sb.
- Storage uses a generate loop over NREGS. There are no per-register named instances.

## Test plan
- Reset and write/read: clear for 1 cycle; ir ra=3, gra, rin, bus_in=0xDEADBEEF. Next cycle: rout → bus_out=0xDEADBEEF; all other registers read 0.
- R0 zero under baout: write R0=0x12345678. Then baout with rb=0 → bus_out=0. Then rout → 0x12345678.
- Scoreboard: reserve with rc=5 → busy[5]=1. rout on R5 → busy_hit=1. wb_valid idx=5, data=0xA5A5A5A5 → next cycle busy[5]=0, busy_hit=0, R5 reads 0xA5A5A5A5.
- Collisions: same cycle, rin with bus_in=0x1 and wb_valid with data=0x2 to R7 → R7=0x1, busy[7]=0. Same cycle, reserve and wb to R7 → R7=wb_data, busy[7]=1.
- Error and sign extension: wb to non-busy R9 → wb_err=1, held until clear. ir[18:0]=0x40000 → c_sign_extended=0xFFFC0000.
- Parametrisation: re-run tests 1 and 3 with WIDTH=64 and NREGS=32, IDX_W=5, RA_LSB=22, RB_LSB=17, RC_LSB=12. Results must match with widened values.
